// File: rtl/raven_uart_pkg.sv
// Shared encodings for the Raven UART receiver: FSM states and parity mode codes.
// Parity support is compiled in only with RAVEN_UART_RX_PARITY_EN; the codes are always available.
package raven_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic par_active(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/raven_uart_rx_mon_if.sv
// Read-side handshake of the UART receive FIFO: head character plus error flags, valid/ready pop.
// master drives the character stream, slave consumes it.
interface raven_uart_rx_mon_if #(parameter int DATA_BITS = 8);
  logic                 rd_valid;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_ferr;
  logic                 rd_perr;
  logic                 rd_ready;

  modport master (output rd_valid, rd_data, rd_ferr, rd_perr, input rd_ready);
  modport slave  (input rd_valid, rd_data, rd_ferr, rd_perr, output rd_ready);
endinterface

// File: rtl/raven_uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; push is refused when full unless a pop frees a slot that cycle.
// While empty, dout shows the most recently popped entry (zero after reset).
module raven_uart_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] prev_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level == '0);
  assign full     = (level == LVL_W'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign prev_ptr = rd_ptr - 1'b1;
  // The slot behind rd_ptr still holds the last popped entry until a push lands at rd_ptr.
  assign dout     = empty ? mem[prev_ptr] : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

endmodule

// File: rtl/raven_uart_rx_mon.sv
// UART receiver/monitor with RX FIFO; parity checking compiled in with RAVEN_UART_RX_PARITY_EN.
// Entry valid the cycle after the stop-bit sample; full FIFO drops the character and sets sticky overrun.
module raven_uart_rx_mon
  import raven_uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_en,
  input  logic [DIV_WIDTH-1:0]          cfg_div,
  input  logic [1:0]                    cfg_parity,
  input  logic                          ser_rx,
  raven_uart_rx_mon_if.master           rd,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int BIT_W = $clog2(DATA_BITS);
`ifdef RAVEN_UART_RX_PARITY_EN
  localparam int ENTRY_W = DATA_BITS + 2;
`else
  localparam int ENTRY_W = DATA_BITS + 1;
`endif

  logic [1:0]           sync_q;
  logic                 rxs;
  rx_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 armed_q, armed_d;
  logic                 push;
  logic [ENTRY_W-1:0]   push_data;
  logic [ENTRY_W-1:0]   fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign rxs     = sync_q[1];
  assign div_eff = (cfg_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_div;

`ifdef RAVEN_UART_RX_PARITY_EN
  logic [1:0] par_q, par_d;
  logic       perr_q, perr_d;
  logic       par_exp;

  assign par_exp   = (par_q == PAR_ODD) ? ~(^shift_q) : ^shift_q;
  assign push_data = {perr_q, ~rxs, shift_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      par_q  <= PAR_NONE;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
`else
  logic unused_parity;
  assign unused_parity = ^cfg_parity;
  assign push_data     = {~rxs, shift_q};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_WIDTH'(2);
      bit_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], ser_rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    armed_d = armed_q;
    push    = 1'b0;
`ifdef RAVEN_UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    if (!cfg_en) begin
      state_d = ST_IDLE;
      armed_d = armed_q | rxs;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rxs) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            // Counting half a bit from the falling edge centres every later sample.
            state_d = ST_START;
            div_d   = div_eff;
            cnt_d   = (div_eff >> 1) - 1'b1;
`ifdef RAVEN_UART_RX_PARITY_EN
            par_d   = cfg_parity;
            perr_d  = 1'b0;
`endif
          end
        end
        ST_START: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (rxs) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            cnt_d   = div_q - 1'b1;
            bit_d   = '0;
          end
        end
        ST_DATA: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            cnt_d   = div_q - 1'b1;
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef RAVEN_UART_RX_PARITY_EN
              state_d = par_active(par_q) ? ST_PARITY : ST_STOP;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
`ifdef RAVEN_UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            perr_d  = (rxs != par_exp);
            cnt_d   = div_q - 1'b1;
            state_d = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            // A break (line still low) leaves the receiver disarmed until the line idles high.
            push    = 1'b1;
            state_d = ST_IDLE;
            armed_d = rxs;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  raven_uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (rd.rd_ready),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign rd.rd_valid = ~fifo_empty;
  assign rd.rd_data  = fifo_dout[DATA_BITS-1:0];
  assign rd.rd_ferr  = fifo_dout[DATA_BITS];
`ifdef RAVEN_UART_RX_PARITY_EN
  assign rd.rd_perr  = fifo_dout[DATA_BITS+1];
`else
  assign rd.rd_perr  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (push && fifo_full && !(rd.rd_valid && rd.rd_ready)) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_raven_uart_rx_mon.sv
// Directed bench for raven_uart_rx_mon: frames are bit-banged on ser_rx and the FIFO is popped at negedge.
// Parity scenarios run only when RAVEN_UART_RX_PARITY_EN is defined.
module tb_raven_uart_rx_mon;
  localparam int DB = 8;
  localparam int DW = 16;
  localparam int FD = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_en;
  logic [DW-1:0] cfg_div;
  logic [1:0]    cfg_parity;
  logic          ser_rx;
  logic          overrun;
  logic          overrun_clr;
  logic [4:0]    fifo_level;
  int            errors = 0;
  int            checks = 0;

  raven_uart_rx_mon_if #(.DATA_BITS(DB)) rd_if ();

  raven_uart_rx_mon #(.DATA_BITS(DB), .DIV_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_en      (cfg_en),
    .cfg_div     (cfg_div),
    .cfg_parity  (cfg_parity),
    .ser_rx      (ser_rx),
    .rd          (rd_if.master),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // par_bit < 0 sends no parity bit; the line is left at the stop-bit level.
  task automatic send_char(input logic [7:0] d, input int div, input logic stop_bit, input int par_bit);
    ser_rx = 1'b0;
    idle(div);
    for (int i = 0; i < DB; i++) begin
      ser_rx = d[i];
      idle(div);
    end
    if (par_bit >= 0) begin
      ser_rx = (par_bit != 0);
      idle(div);
    end
    ser_rx = stop_bit;
    idle(div);
  endtask

  task automatic pop_entry(output logic v, output logic [7:0] d, output logic f, output logic p);
    v = rd_if.rd_valid;
    d = rd_if.rd_data;
    f = rd_if.rd_ferr;
    p = rd_if.rd_perr;
    rd_if.rd_ready = 1'b1;
    idle(1);
    rd_if.rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    checks++; if (rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rd_if.rd_valid); end
    checks++; if (rd_if.rd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rd_if.rd_data); end
    checks++; if (rd_if.rd_ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", rd_if.rd_ferr); end
    checks++; if (rd_if.rd_perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", rd_if.rd_perr); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_back_to_back();
    logic v, f, p;
    logic [7:0] d;
    cfg_div = 16'd8;
    idle(8);
    send_char(8'h55, 8, 1'b1, -1);
    send_char(8'hA3, 8, 1'b1, -1);
    idle(16);
    checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL b2b_level: got %0d expected 2", fifo_level); end
    pop_entry(v, d, f, p);
    checks++; if ({v, d, f, p} !== {1'b1, 8'h55, 1'b0, 1'b0}) begin errors++; $display("FAIL b2b_first: got v=%b d=%h f=%b p=%b expected v=1 d=55 f=0 p=0", v, d, f, p); end
    pop_entry(v, d, f, p);
    checks++; if ({v, d, f, p} !== {1'b1, 8'hA3, 1'b0, 1'b0}) begin errors++; $display("FAIL b2b_second: got v=%b d=%h f=%b p=%b expected v=1 d=a3 f=0 p=0", v, d, f, p); end
    checks++; if (rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got valid %b expected 0", rd_if.rd_valid); end
  endtask

  task automatic test_glitch();
    logic v, f, p;
    logic [7:0] d;
    cfg_div = 16'd16;
    ser_rx = 1'b0;
    idle(3);
    ser_rx = 1'b1;
    idle(40);
    checks++; if (rd_if.rd_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", rd_if.rd_valid); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL glitch_level: got %0d expected 0", fifo_level); end
    send_char(8'h5A, 16, 1'b1, -1);
    idle(32);
    pop_entry(v, d, f, p);
    checks++; if ({v, d, f} !== {1'b1, 8'h5A, 1'b0}) begin errors++; $display("FAIL glitch_recover: got v=%b d=%h f=%b expected v=1 d=5a f=0", v, d, f); end
  endtask

  task automatic test_framing();
    logic v, f, p;
    logic [7:0] d;
    cfg_div = 16'd8;
    send_char(8'h3C, 8, 1'b0, -1);
    idle(8 * 40);
    checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL break_level: got %0d expected 1", fifo_level); end
    pop_entry(v, d, f, p);
    checks++; if ({v, d, f} !== {1'b1, 8'h3C, 1'b1}) begin errors++; $display("FAIL break_entry: got v=%b d=%h f=%b expected v=1 d=3c f=1", v, d, f); end
    ser_rx = 1'b1;
    idle(16);
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL break_rearm_level: got %0d expected 0", fifo_level); end
    send_char(8'h21, 8, 1'b1, -1);
    idle(16);
    pop_entry(v, d, f, p);
    checks++; if ({v, d, f} !== {1'b1, 8'h21, 1'b0}) begin errors++; $display("FAIL break_after: got v=%b d=%h f=%b expected v=1 d=21 f=0", v, d, f); end
  endtask

  task automatic test_overrun();
    logic v, f, p;
    logic [7:0] d;
    logic [7:0] exp_q [FD+1];
    for (int i = 0; i <= FD; i++) exp_q[i] = 8'(i * 13 + 5);
    cfg_div = 16'd8;
    for (int i = 0; i <= FD; i++) send_char(exp_q[i], 8, 1'b1, -1);
    idle(16);
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovr_level: got %0d expected 16", fifo_level); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    for (int i = 0; i < FD; i++) begin
      pop_entry(v, d, f, p);
      checks++; if ({v, d} !== {1'b1, exp_q[i]}) begin errors++; $display("FAIL ovr_pop%0d: got v=%b d=%h expected v=1 d=%h", i, v, d, exp_q[i]); end
    end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL ovr_drained: got %0d expected 0", fifo_level); end
    rd_if.rd_ready = 1'b1;
    idle(2);
    rd_if.rd_ready = 1'b0;
    checks++; if ({rd_if.rd_valid, fifo_level} !== {1'b0, 5'd0}) begin errors++; $display("FAIL empty_pop: got valid=%b level=%0d expected valid=0 level=0", rd_if.rd_valid, fifo_level); end
    checks++; if (rd_if.rd_data !== exp_q[FD-1]) begin errors++; $display("FAIL empty_hold: got %h expected %h", rd_if.rd_data, exp_q[FD-1]); end
  endtask

  task automatic test_small_div();
    logic v, f, p;
    logic [7:0] d;
    cfg_div = 16'd1;
    idle(4);
    send_char(8'h96, 2, 1'b1, -1);
    idle(8);
    pop_entry(v, d, f, p);
    checks++; if ({v, d, f} !== {1'b1, 8'h96, 1'b0}) begin errors++; $display("FAIL div_min: got v=%b d=%h f=%b expected v=1 d=96 f=0", v, d, f); end
    cfg_div = 16'd8;
  endtask

  task automatic test_enable();
    logic v, f, p;
    logic [7:0] d;
    cfg_div = 16'd8;
    idle(8);
    ser_rx = 1'b0; idle(8);
    ser_rx = 1'b1; idle(8);
    ser_rx = 1'b0; idle(8);
    ser_rx = 1'b1; idle(4);
    cfg_en = 1'b0;
    idle(12);
    cfg_en = 1'b1;
    idle(8);
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL en_partial: got level %0d expected 0", fifo_level); end
    send_char(8'h81, 8, 1'b1, -1);
    idle(16);
    checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL en_level: got %0d expected 1", fifo_level); end
    pop_entry(v, d, f, p);
    checks++; if ({v, d, f} !== {1'b1, 8'h81, 1'b0}) begin errors++; $display("FAIL en_char: got v=%b d=%h f=%b expected v=1 d=81 f=0", v, d, f); end
  endtask

`ifdef RAVEN_UART_RX_PARITY_EN
  task automatic test_parity();
    logic v, f, p;
    logic [7:0] d;
    cfg_div = 16'd8;
    cfg_parity = 2'b01;
    send_char(8'h07, 8, 1'b1, 0);
    idle(16);
    pop_entry(v, d, f, p);
    checks++; if ({v, d, f, p} !== {1'b1, 8'h07, 1'b0, 1'b1}) begin errors++; $display("FAIL par_even_bad: got v=%b d=%h f=%b p=%b expected p=1", v, d, f, p); end
    send_char(8'h07, 8, 1'b1, 1);
    idle(16);
    pop_entry(v, d, f, p);
    checks++; if ({v, d, f, p} !== {1'b1, 8'h07, 1'b0, 1'b0}) begin errors++; $display("FAIL par_even_ok: got v=%b d=%h f=%b p=%b expected p=0", v, d, f, p); end
    cfg_parity = 2'b10;
    send_char(8'h07, 8, 1'b1, 0);
    idle(16);
    pop_entry(v, d, f, p);
    checks++; if ({v, d, f, p} !== {1'b1, 8'h07, 1'b0, 1'b0}) begin errors++; $display("FAIL par_odd_ok: got v=%b d=%h f=%b p=%b expected p=0", v, d, f, p); end
    cfg_parity = 2'b00;
  endtask
`endif

  task automatic test_reset_midframe();
    logic v, f, p;
    logic [7:0] d;
    cfg_div = 16'd8;
    send_char(8'h44, 8, 1'b1, -1);
    idle(8);
    ser_rx = 1'b0;
    idle(20);
    reset = 1'b1;
    idle(2);
    ser_rx = 1'b1;
    reset = 1'b0;
    checks++; if ({rd_if.rd_valid, fifo_level} !== {1'b0, 5'd0}) begin errors++; $display("FAIL rst_mid_fifo: got valid=%b level=%0d expected 0 0", rd_if.rd_valid, fifo_level); end
    checks++; if (rd_if.rd_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", rd_if.rd_data); end
    idle(16);
    send_char(8'h18, 8, 1'b1, -1);
    idle(16);
    pop_entry(v, d, f, p);
    checks++; if ({v, d, f} !== {1'b1, 8'h18, 1'b0}) begin errors++; $display("FAIL rst_mid_after: got v=%b d=%h f=%b expected v=1 d=18 f=0", v, d, f); end
  endtask

  initial begin
    reset = 1'b1;
    cfg_en = 1'b1;
    cfg_div = 16'd8;
    cfg_parity = 2'b00;
    ser_rx = 1'b1;
    overrun_clr = 1'b0;
    rd_if.rd_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_overrun();
    test_small_div();
    test_enable();
`ifdef RAVEN_UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
